// File: rtl/note_track_sequencer.sv
// Two-lane note-track scroller: takes 32-beat patterns from a loader, double-buffers
// them through one shadow slot, and scrolls them to the LED display on beat_tick.
module note_track_sequencer (
  input  logic        clk,
  input  logic        nrst,
  input  logic [2:0]  mode,
  input  logic        beat_tick,
  input  logic        pat_valid,
  input  logic [31:0] pat_note1,
  input  logic [31:0] pat_note2,
  input  logic        pat_last,
  output logic        pat_ready,
  output logic [31:0] next_note1,
  output logic [31:0] next_note2,
  output logic [4:0]  next_idx1,
  output logic [4:0]  next_idx2,
  output logic        song_done,
  output logic        underrun,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    PLAY  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] PLAY_MODE = 3'd2;
  localparam logic [4:0] LAST_BEAT = 5'd31;
  localparam logic [2:0] DRAIN_END = 3'd6;

  state_t      state_q, state_d;
  logic [31:0] act1_q, act1_d, act2_q, act2_d;
  logic        act_last_q, act_last_d;
  logic [31:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic        sh_last_q, sh_last_d;
  logic        sh_valid_q, sh_valid_d;
  logic        last_seen_q, last_seen_d;
  logic [4:0]  idx_q, idx_d;
  logic [2:0]  drain_q, drain_d;
  logic        done_q, done_d;
  logic        urun_q, urun_d;

  logic play_mode;
  logic xfer;
  logic wrap_tick;

  // Handshake: a pattern moves when pat_valid and pat_ready are both high at a
  // rising clk edge. pat_ready is the only output allowed to depend on inputs
  // combinationally (it is gated by mode so no pattern is taken while leaving play).
  assign play_mode = (mode == PLAY_MODE);
  assign pat_ready = play_mode &&
                     ((state_q == FILL) ||
                      ((state_q == PLAY) && !sh_valid_q && !last_seen_q));
  assign xfer      = pat_valid && pat_ready;
  assign wrap_tick = beat_tick && (idx_q == LAST_BEAT);

  assign next_note1 = act1_q;
  assign next_note2 = act2_q;
  assign next_idx1  = idx_q;
  assign next_idx2  = idx_q;
  assign song_done  = done_q;
  assign underrun   = urun_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      act1_q      <= '0;
      act2_q      <= '0;
      act_last_q  <= 1'b0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      sh_last_q   <= 1'b0;
      sh_valid_q  <= 1'b0;
      last_seen_q <= 1'b0;
      idx_q       <= '0;
      drain_q     <= '0;
      done_q      <= 1'b0;
      urun_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      act1_q      <= act1_d;
      act2_q      <= act2_d;
      act_last_q  <= act_last_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      sh_last_q   <= sh_last_d;
      sh_valid_q  <= sh_valid_d;
      last_seen_q <= last_seen_d;
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      done_q      <= done_d;
      urun_q      <= urun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    act1_d      = act1_q;
    act2_d      = act2_q;
    act_last_d  = act_last_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
    sh_last_d   = sh_last_q;
    sh_valid_d  = sh_valid_q;
    last_seen_d = last_seen_q;
    idx_d       = idx_q;
    drain_d     = drain_q;
    done_d      = done_q;
    urun_d      = urun_q;

    if (!play_mode) begin
      state_d     = IDLE;
      act1_d      = '0;
      act2_d      = '0;
      act_last_d  = 1'b0;
      sh1_d       = '0;
      sh2_d       = '0;
      sh_last_d   = 1'b0;
      sh_valid_d  = 1'b0;
      last_seen_d = 1'b0;
      idx_d       = '0;
      drain_d     = '0;
      done_d      = 1'b0;
      urun_d      = 1'b0;
    end else begin
      if (xfer && pat_last) begin
        last_seen_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          state_d = FILL;
        end
        FILL: begin
          if (xfer) begin
            act1_d     = pat_note1;
            act2_d     = pat_note2;
            act_last_d = pat_last;
            idx_d      = '0;
            state_d    = PLAY;
          end
        end
        PLAY: begin
          if (wrap_tick) begin
            // End of the active pattern: finish the song, swap in the shadow,
            // let a same-cycle transfer bypass, or stall at beat 31.
            if (act_last_q) begin
              act1_d  = '0;
              act2_d  = '0;
              idx_d   = '0;
              drain_d = '0;
              state_d = DRAIN;
            end else if (sh_valid_q) begin
              act1_d     = sh1_q;
              act2_d     = sh2_q;
              act_last_d = sh_last_q;
              sh_valid_d = 1'b0;
              idx_d      = '0;
            end else if (xfer) begin
              act1_d     = pat_note1;
              act2_d     = pat_note2;
              act_last_d = pat_last;
              idx_d      = '0;
            end else begin
              urun_d = 1'b1;
            end
          end else begin
            if (beat_tick) begin
              idx_d = idx_q + 5'd1;
            end
            if (xfer) begin
              sh1_d      = pat_note1;
              sh2_d      = pat_note2;
              sh_last_d  = pat_last;
              sh_valid_d = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (beat_tick) begin
            if (drain_q == DRAIN_END) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 5'd1;
              drain_d = drain_q + 3'd1;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
